// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one 8-function ALU into a single result slot.
// Define ALU_ARB_DBZ_FLAG_EN to add the res_err divide/modulo-by-zero flag.
module alu_share_arbiter #(
  parameter int DATA_W    = 4,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_sel,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W:0]   res_data,
  output logic              res_tag
`ifdef ALU_ARB_DBZ_FLAG_EN
  ,
  output logic              res_err
`endif
);

  localparam int RW = DATA_W + 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_nx;

  logic          last_grant;
  logic          grant0, grant1;
  logic          can_accept;
  logic          accept;
  logic [DATA_W-1:0] op_a, op_b;
  logic [2:0]    op_sel;
  logic [RW-1:0] alu_out;
  logic          dbz;

  function automatic logic [RW-1:0] alu(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [2:0]        sel
  );
    logic [RW-1:0] za, zb, r;
    za = {1'b0, a};
    zb = {1'b0, b};
    r  = '0;
    case (sel)
      3'b000: r = za;
      3'b001: r = za + zb;
      3'b010: r = za - zb;
      3'b011: r = (b == '0) ? '1 : za / zb;
      3'b100: r = (b == '0) ? za : za % zb;
      3'b101: r = za << 1;
      3'b110: r = za >> 1;
      3'b111: r = {{DATA_W{1'b0}}, (a > b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Ties go to port 0 under fixed priority, else to the port not served last.
  assign grant0 = req0_valid &
                  (!req1_valid || (FIXED_PRI != 0) || last_grant);
  assign grant1 = req1_valid & !grant0;

  assign can_accept = (state == EMPTY) || res_ready;
  assign req0_ready = !rst && can_accept && grant0;
  assign req1_ready = !rst && can_accept && grant1;
  assign accept     = req0_ready | req1_ready;

  assign op_a   = grant1 ? req1_a : req0_a;
  assign op_b   = grant1 ? req1_b : req0_b;
  assign op_sel = grant1 ? req1_sel : req0_sel;

  assign alu_out = alu(op_a, op_b, op_sel);
  assign dbz     = ((op_sel == 3'b011) || (op_sel == 3'b100)) &&
                   (op_b == '0);

  assign res_valid = (state == FULL);

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY: if (accept) state_nx = FULL;
      FULL:  if (res_ready && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      res_data   <= '0;
      res_tag    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (accept) begin
        res_data   <= alu_out;
        res_tag    <= grant1;
        last_grant <= grant1;
      end
    end
  end

`ifdef ALU_ARB_DBZ_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_err <= 1'b0;
    end else if (accept) begin
      res_err <= dbz;
    end
  end
`else
  logic unused_dbz;
  assign unused_dbz = dbz;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 8-function ALU between two requesters (port 0, port 1).
- Requesters present operands and an opcode on a valid/ready handshake.
- The block arbitrates between them, executes the operation, and holds the result in a single registered output slot, tagged with the winning requester.
- It sits between the front-end command sources and the result consumer.

Parameters:
DATA_W, 4, operand width; result width is DATA_W+1
FIXED_PRI, 0, 0 = round-robin between ports; 1 = port 0 always wins

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  port 0 request present
req0_ready  output  1  port 0 request accepted this cycle
req0_a  input  DATA_W  port 0 operand a
req0_b  input  DATA_W  port 0 operand b
req0_sel  input  3  port 0 opcode
req1_valid/req1_ready/req1_a/req1_b/req1_sel  same as port 0, for port 1
res_valid  output  1  result slot full
res_ready  input  1  consumer takes result this cycle
res_data  output  DATA_W+1  result
res_tag  output  1  0 = port 0 result, 1 = port 1 result

Behaviour:
- **Clock and reset:** one clock, clk. Reset rst is asynchronous, active-high.
- **Reset values:** res_valid=0, res_data=0, res_tag=0, last_grant=1 (so port 0 wins the first tie). req*_ready is combinational and is 0 while rst is high.
- **Slot state:** two states, EMPTY (res_valid=0) and FULL (res_valid=1).
- **Slot can accept** when state is EMPTY, or when state is FULL and res_ready=1 (same-cycle drain and refill).
- **Grant rule (combinational):**
  - Only one port requests: that port is granted.
  - Both request with FIXED_PRI=1: port 0 is granted.
  - Both request with FIXED_PRI=0: the port not equal to last_grant is granted.
- **Handshake:** reqN_ready = slot can accept AND grantN. At most one ready is high per cycle.
  - A requester must hold its valid and operands stable until ready.
  - A port that is not granted sees ready=0.
- **Transfer:** on reqN_valid & reqN_ready at a rising edge:
  - res_data = f(a, b, sel), res_tag = N, res_valid = 1, last_grant = N.
  - Latency is 1 cycle from acceptance to res_valid.
- **Drain without refill:** res_valid & res_ready with no request accepted gives res_valid=0 next cycle. res_data and res_tag hold their last value.
- **Stall:** res_valid=1 and res_ready=0 gives all output bits held stable and both readies low.
- **Opcode functions** (a and b zero-extended to DATA_W+1):
  - 000: a
  - 001: a+b, carry lands in the MSB
  - 010: a-b, modulo 2^(DATA_W+1); borrow wraps
  - 011: a/b; if b=0, all ones
  - 100: a%b; if b=0, a
  - 101: a<<1, MSB of a lands in the MSB of the result
  - 110: a>>1
  - 111: 1 if a>b, else 0
- **Reset mid-operation:** an asserted rst clears a pending result immediately, without waiting for a clock edge. The first grant after reset follows the reset value of last_grant.

Optional Feature:
- **Macro:** ALU_ARB_DBZ_FLAG_EN.
- **When defined:**
  - Adds output port res_err (1 bit, reset 0).
  - res_err is registered alongside res_data: 1 when the accepted opcode was 011 or 100 and b=0, else 0.
  - res_err holds under stall exactly as res_data does.
- **When undefined:**
  - The port is absent.
  - Divide/modulo-by-zero results are still as defined above.

Test Plan:
1. **Single port:** reset, then req0 with a=9, b=3, sel=001, res_ready=1.
   - Required: req0_ready=1 that cycle, next cycle res_valid=1, res_data=12, res_tag=0.
2. **Tie, round-robin (FIXED_PRI=0):**
   - Stimulus: both ports valid continuously. Port 0: a=9, b=3, sel=010. Port 1: a=9, b=3, sel=011. res_ready=1.
   - Required: grants alternate 0,1,0,1. Results alternate 6 (tag 0) and 3 (tag 1), one per cycle, no bubbles.
3. **Backpressure:**
   - Stimulus: res_ready=0 after the first result (a=9, sel=101, giving 18).
   - Required: res_data holds 18 and both readies stay 0 for 5 cycles. Raising res_ready drains it, and the pending request is accepted in the same cycle.
4. **Corner opcodes:**
   - a=9, b=0, sel=011 gives 31.
   - sel=100 gives 9.
   - a=3, b=9, sel=010 gives 26.
   - a=9, b=3, sel=111 gives 1.
   - a=9, sel=110 gives 4.
   - With ALU_ARB_DBZ_FLAG_EN defined: res_err=1 for the first two cases only.
5. **FIXED_PRI=1:** both ports always valid.
   - Required: port 0 is granted every cycle and req1_ready stays 0.
6. **Async reset:** assert rst mid-cycle while res_valid=1 and stalled.
   - Required: res_valid=0 before the next clock edge. After release, on a tie, port 0 is granted first.
